// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, default line settings and
// the oversampling divider calculation used by both link directions.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_state_e;

  localparam int unsigned DEFAULT_F_IN       = 50_000_000;
  localparam int unsigned DEFAULT_BAUD       = 9600;
  localparam int unsigned DEFAULT_OVERSAMPLE = 16;

  // System clocks per oversampling tick, truncated.
  function automatic int unsigned calc_div(input int unsigned f_in,
                                           input int unsigned baud,
                                           input int unsigned oversample);
    return f_in / (baud * oversample);
  endfunction

endpackage

// File: rtl/uart_tick_gen.sv
// Free-running divider producing a one-cycle enable every DIV clocks; reload
// restarts the count so the tick phase can be aligned to an external event.
module uart_tick_gen #(
  parameter int unsigned DIV = 325
) (
  input  logic in_clk,
  input  logic nrst,
  input  logic reload,
  output logic tick
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  assign tick = (cnt == LAST);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge in_clk or negedge nrst) begin
    if (!nrst) begin
      cnt <= '0;
    end else if (reload || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1-style UART receiver: synchronises rx, detects the start edge, samples
// each bit mid-period with an oversampling tick and reports bytes or stop errors.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned F_IN       = DEFAULT_F_IN,
  parameter int unsigned BAUD       = DEFAULT_BAUD,
  parameter int unsigned OVERSAMPLE = DEFAULT_OVERSAMPLE,
  parameter int unsigned DATA_BITS  = 8
) (
  input  logic                 in_clk,
  input  logic                 nrst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int unsigned DIV = calc_div(F_IN, BAUD, OVERSAMPLE);
  localparam int unsigned SW  = $clog2(OVERSAMPLE);
  localparam int unsigned BW  = (DATA_BITS > 1) ? $clog2(DATA_BITS + 1) : 1;

  localparam logic [SW-1:0] SAMP_MID  = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] SAMP_LAST = SW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

  uart_state_e          state;
  logic                 rx_meta;
  logic                 rx_s;
  logic                 rx_prev;
  logic                 armed;
  logic [SW-1:0]        samp;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shift;
  logic                 tick;
  logic                 start_det;

  // NOTE: the synchroniser resets to the idle line level (1) so releasing
  // reset with rx high never looks like a start edge.
  always_ff @(posedge in_clk or negedge nrst) begin
    if (!nrst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
      rx_prev <= rx_s;
    end
  end

  assign start_det = (state == IDLE) && armed && rx_prev && !rx_s;

  uart_tick_gen #(
    .DIV (DIV)
  ) u_tick_gen (
    .in_clk (in_clk),
    .nrst   (nrst),
    .reload (start_det),
    .tick   (tick)
  );

  always_ff @(posedge in_clk or negedge nrst) begin
    if (!nrst) begin
      state     <= IDLE;
      samp      <= '0;
      bit_cnt   <= '0;
      shift     <= '0;
      data      <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      busy      <= 1'b0;
      armed     <= 1'b1;
    end else begin
      valid     <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          busy <= 1'b0;
          if (rx_s) armed <= 1'b1;
          if (start_det) begin
            state <= START;
            samp  <= '0;
            busy  <= 1'b1;
          end
        end
        START: if (tick) begin
          if (samp == SAMP_MID) begin
            samp <= '0;
            if (!rx_s) begin
              state   <= DATA;
              bit_cnt <= '0;
            end else begin
              state <= IDLE;  // start bit did not hold to mid-bit: a glitch
              busy  <= 1'b0;
            end
          end else begin
            samp <= samp + 1'b1;
          end
        end
        DATA: if (tick) begin
          if (samp == SAMP_LAST) begin
            samp    <= '0;
            shift   <= DATA_BITS'({rx_s, shift} >> 1);
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == BIT_LAST) state <= STOP;
          end else begin
            samp <= samp + 1'b1;
          end
        end
        STOP: if (tick) begin
          if (samp == SAMP_LAST) begin
            // Leaving at mid stop bit lets an immediately following start edge be seen.
            state <= IDLE;
            samp  <= '0;
            busy  <= 1'b0;
            if (rx_s) begin
              data  <= shift;
              valid <= 1'b1;
            end else begin
              frame_err <= 1'b1;
              armed     <= 1'b0;
            end
          end else begin
            samp <= samp + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: scenario tasks drive serial frames and
// compare the decoded bytes and strobes against a frame-level expectation queue.
module tb_uart_rx;

  localparam int F_IN = 1_600_000;
  localparam int BAUD = 10_000;
  localparam int OS   = 16;
  localparam int BIT  = F_IN / BAUD;  // clocks per bit period

  logic       in_clk = 1'b0;
  logic       nrst;
  logic       rx;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic       busy;

  int checks = 0;
  int errors = 0;

  int         cyc = 0;
  logic [7:0] got_q[$];
  int         fe_cnt = 0;
  int         both_cnt = 0;
  int         busy_bad = 0;
  int         last_valid_cyc = 0;
  logic       prev_busy = 1'b0;

  uart_rx #(
    .F_IN       (F_IN),
    .BAUD       (BAUD),
    .OVERSAMPLE (OS),
    .DATA_BITS  (8)
  ) dut (
    .in_clk    (in_clk),
    .nrst      (nrst),
    .rx        (rx),
    .data      (data),
    .valid     (valid),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #5 in_clk = ~in_clk;

  always @(posedge in_clk) cyc++;

  // Observer: records every received byte and strobe event for the scenario tasks.
  always @(negedge in_clk) begin
    if (nrst === 1'b1) begin
      if (valid === 1'b1) begin
        got_q.push_back(data);
        last_valid_cyc = cyc;
        if (busy !== 1'b0 || prev_busy !== 1'b1) busy_bad++;
      end
      if (frame_err === 1'b1) fe_cnt++;
      if (valid === 1'b1 && frame_err === 1'b1) both_cnt++;
    end
    prev_busy = busy;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic hold(input logic v, input int n);
    rx = v;
    repeat (n) @(negedge in_clk);
  endtask

  task automatic send_bits(input logic [7:0] b);
    hold(1'b0, BIT);
    for (int i = 0; i < 8; i++) hold(b[i], BIT);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_ok);
    send_bits(b);
    if (stop_ok) hold(1'b1, BIT);
    else hold(1'b0, 3 * BIT);
    rx = 1'b1;
  endtask

  task automatic test_reset;
    nrst = 1'b0;
    rx   = 1'b1;
    repeat (5) @(negedge in_clk);
    checks += 4;
    if (data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", data); end
    if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", valid); end
    if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err: got %b want 0", frame_err); end
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    nrst = 1'b1;
    repeat (20) @(negedge in_clk);
    checks += 4;
    if (data !== 8'h00) begin errors++; $display("FAIL release_data: got %h want 00", data); end
    if (valid !== 1'b0) begin errors++; $display("FAIL release_valid: got %b want 0", valid); end
    if (frame_err !== 1'b0) begin errors++; $display("FAIL release_frame_err: got %b want 0", frame_err); end
    if (busy !== 1'b0) begin errors++; $display("FAIL release_busy: got %b want 0", busy); end
  endtask

  task automatic test_single_frame;
    int base, fe0, bb0, start_cyc, lat, lat_exp;
    base = got_q.size(); fe0 = fe_cnt; bb0 = busy_bad;
    start_cyc = cyc;
    send_frame(8'hA5, 1'b1);
    hold(1'b1, 2 * BIT);
    lat     = last_valid_cyc - start_cyc;
    lat_exp = 2 + (19 * BIT) / 2;
    checks += 6;
    if (got_q.size() - base != 1) begin
      errors++; $display("FAIL single_count: got %0d want 1", got_q.size() - base);
    end else if (got_q[base] !== 8'hA5) begin
      errors++; $display("FAIL single_byte: got %h want a5", got_q[base]);
    end
    if (fe_cnt != fe0) begin errors++; $display("FAIL single_frame_err: got %0d pulses want 0", fe_cnt - fe0); end
    if (busy_bad != bb0) begin errors++; $display("FAIL single_busy_fall: busy not falling with valid"); end
    if (data !== 8'hA5) begin errors++; $display("FAIL single_data: got %h want a5", data); end
    if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_idle: got %b want 0", busy); end
    if (lat < lat_exp - 3 || lat > lat_exp + 3) begin
      errors++; $display("FAIL single_latency: got %0d want %0d", lat, lat_exp);
    end
  endtask

  task automatic test_glitch;
    int base, fe0, waited;
    logic seen;
    base = got_q.size(); fe0 = fe_cnt;
    seen = 1'b0; waited = 0;
    rx = 1'b0;
    while (!seen && waited < 20) begin
      @(negedge in_clk);
      waited++;
      if (busy === 1'b1) seen = 1'b1;
    end
    hold(1'b0, (3 * BIT) / 8 - waited);
    hold(1'b1, 2 * BIT);
    checks += 4;
    if (seen !== 1'b1) begin errors++; $display("FAIL glitch_busy_rise: busy not seen within 20 cycles"); end
    if (busy !== 1'b0) begin errors++; $display("FAIL glitch_busy_clear: got %b want 0", busy); end
    if (got_q.size() != base) begin errors++; $display("FAIL glitch_valid: got %0d bytes want 0", got_q.size() - base); end
    if (fe_cnt != fe0) begin errors++; $display("FAIL glitch_frame_err: got %0d pulses want 0", fe_cnt - fe0); end
  endtask

  task automatic test_frame_error;
    int base, fe0, busy_hi;
    base = got_q.size(); fe0 = fe_cnt; busy_hi = 0;
    send_bits(8'h3C);
    rx = 1'b0;
    for (int i = 0; i < 3 * BIT; i++) begin
      @(negedge in_clk);
      if (i > BIT && busy !== 1'b0) busy_hi++;
    end
    hold(1'b1, 2 * BIT);
    checks += 5;
    if (fe_cnt - fe0 != 1) begin errors++; $display("FAIL ferr_pulses: got %0d want 1", fe_cnt - fe0); end
    if (got_q.size() != base) begin errors++; $display("FAIL ferr_valid: got %0d bytes want 0", got_q.size() - base); end
    if (data !== 8'hA5) begin errors++; $display("FAIL ferr_data: got %h want a5", data); end
    if (busy_hi != 0) begin errors++; $display("FAIL ferr_rearm: busy high %0d cycles while line low", busy_hi); end
    if (both_cnt != 0) begin errors++; $display("FAIL ferr_overlap: valid and frame_err together %0d times", both_cnt); end
  endtask

  task automatic test_back_to_back;
    int base, fe0;
    base = got_q.size(); fe0 = fe_cnt;
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    hold(1'b1, 2 * BIT);
    checks += 3;
    if (got_q.size() - base != 2) begin
      errors++; $display("FAIL b2b_count: got %0d want 2", got_q.size() - base);
    end else begin
      checks += 1;
      if (got_q[base] !== 8'h00) begin errors++; $display("FAIL b2b_first: got %h want 00", got_q[base]); end
      if (got_q[base+1] !== 8'hFF) begin errors++; $display("FAIL b2b_second: got %h want ff", got_q[base+1]); end
    end
    if (fe_cnt != fe0) begin errors++; $display("FAIL b2b_frame_err: got %0d pulses want 0", fe_cnt - fe0); end
    if (data !== 8'hFF) begin errors++; $display("FAIL b2b_data: got %h want ff", data); end
  endtask

  task automatic test_reset_mid_frame;
    logic [7:0] b;
    int base;
    b = 8'h12;
    base = got_q.size();
    hold(1'b0, BIT);
    for (int i = 0; i < 3; i++) hold(b[i], BIT);
    hold(b[3], BIT / 2);
    checks += 1;
    if (busy !== 1'b1) begin errors++; $display("FAIL midrst_busy_before: got %b want 1", busy); end
    nrst = 1'b0;
    #1;
    checks += 3;
    if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy_async: got %b want 0", busy); end
    if (data !== 8'h00) begin errors++; $display("FAIL midrst_data_async: got %h want 00", data); end
    if (valid !== 1'b0 || frame_err !== 1'b0) begin
      errors++; $display("FAIL midrst_strobes: got valid=%b frame_err=%b want 0/0", valid, frame_err);
    end
    rx = 1'b1;
    repeat (5) @(negedge in_clk);
    nrst = 1'b1;
    hold(1'b1, 2 * BIT);
    checks += 1;
    if (got_q.size() != base) begin errors++; $display("FAIL midrst_no_partial: got %0d bytes want 0", got_q.size() - base); end
    send_frame(8'h55, 1'b1);
    hold(1'b1, 2 * BIT);
    checks += 1;
    if (got_q.size() - base != 1) begin
      errors++; $display("FAIL midrst_next_count: got %0d want 1", got_q.size() - base);
    end else if (got_q[base] !== 8'h55) begin
      errors++; $display("FAIL midrst_next_byte: got %h want 55", got_q[base]);
    end
  endtask

  task automatic test_random;
    logic [7:0] exp_q[$];
    logic [7:0] b, last_good;
    logic       ok;
    int base, fe0, bb0, exp_fe;
    base = got_q.size(); fe0 = fe_cnt; bb0 = busy_bad;
    exp_fe = 0; last_good = 8'h55;
    for (int n = 0; n < 8; n++) begin
      b  = 8'($urandom);
      ok = ($urandom_range(0, 3) != 0);
      send_frame(b, ok);
      if (ok) begin
        exp_q.push_back(b);
        last_good = b;
        hold(1'b1, $urandom_range(0, BIT));
      end else begin
        exp_fe++;
        hold(1'b1, $urandom_range(BIT / 4, 2 * BIT));
      end
    end
    hold(1'b1, 2 * BIT);
    checks += 5;
    if (got_q.size() - base != exp_q.size()) begin
      errors++; $display("FAIL rand_count: got %0d want %0d", got_q.size() - base, exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (got_q[base+i] !== exp_q[i]) begin
          errors++; $display("FAIL rand_byte[%0d]: got %h want %h", i, got_q[base+i], exp_q[i]);
        end
      end
    end
    if (fe_cnt - fe0 != exp_fe) begin errors++; $display("FAIL rand_frame_err: got %0d want %0d", fe_cnt - fe0, exp_fe); end
    if (data !== last_good) begin errors++; $display("FAIL rand_data: got %h want %h", data, last_good); end
    if (both_cnt != 0) begin errors++; $display("FAIL rand_overlap: valid and frame_err together %0d times", both_cnt); end
    if (busy_bad != bb0) begin errors++; $display("FAIL rand_busy_fall: busy not falling with valid"); end
  endtask

  initial begin
    rx   = 1'b1;
    nrst = 1'b0;
    @(negedge in_clk);
    test_reset();
    test_single_frame();
    test_glitch();
    test_frame_error();
    test_back_to_back();
    test_reset_mid_frame();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receiver: the receive end of the serial link whose bit timing the team's frequency divider generates for the transmit side.
- Derives its own oversampling tick from the system clock.
- Synchronises and de-glitches the rx line, then deserialises 8N1 frames LSB-first.
- Presents each received byte with a one-cycle valid strobe and flags bad stop bits.

Parameters:
- F_IN, 50_000_000, system clock frequency in Hz
- BAUD, 9600, line bit rate in bit/s
- OVERSAMPLE, 16, ticks per bit period; must be even and >= 8
- DATA_BITS, 8, data bits per frame (1..8)

Ports:
- in_clk  input  1  system clock, rising edge
- nrst  input  1  reset, asynchronous, active-low
- rx  input  1  serial line; asynchronous to in_clk; idle high
- data  output  DATA_BITS  last correctly received byte
- valid  output  1  one-cycle pulse when data updates
- frame_err  output  1  one-cycle pulse when the stop bit is sampled low
- busy  output  1  high from start-bit detection until the frame ends

Behaviour:
- One clock, in_clk. Reset is asynchronous, active-low, on nrst.
- Reset values:
  - data=0, valid=0, frame_err=0, busy=0.
  - Both synchroniser flops = 1.
  - State=IDLE; tick counter, sample counter and bit counter = 0.
  - armed=1.
- Tick generator:
  - DIV = F_IN/(BAUD*OVERSAMPLE), integer division (defaults: 325).
  - Counter runs 0..DIV-1; tick is high for one cycle when the counter equals DIV-1.
  - Counter reloads to 0 on start detection, which aligns sampling to the falling edge.
- Synchroniser: 2-FF on rx gives rx_s. A falling edge is rx_s=0 with previous rx_s=1.
- States and transitions:
  - IDLE:
    - busy=0.
    - If armed and a falling edge is seen: go to START. Sample counter=0, tick counter reloaded, busy=1 from the next cycle.
    - armed is set whenever rx_s=1 in IDLE.
  - START:
    - Sample counter increments per tick.
    - When it reaches OVERSAMPLE/2-1 (mid-bit): if rx_s=0, go to DATA with sample counter=0 and bit counter=0. If rx_s=1 it was a glitch: go to IDLE and assert nothing.
  - DATA:
    - Per tick, sample counter counts 0..OVERSAMPLE-1.
    - At OVERSAMPLE-1, shift rx_s into the MSB of the shift register (right shift, so the first bit received ends up as LSB) and increment the bit counter.
    - After DATA_BITS samples, go to STOP.
  - STOP:
    - Sample at OVERSAMPLE-1, i.e. mid stop bit.
    - rx_s=1: data <= shift register, valid=1 for exactly one cycle (the cycle after the sampling tick), then go to IDLE.
    - rx_s=0: frame_err=1 for one cycle, data unchanged, armed cleared, then go to IDLE.
- Break / frame-error recovery: with armed=0 no start is detected until rx_s has been 1 for at least one cycle.
- Back-to-back frames: IDLE is re-entered at mid stop bit, so a start edge arriving immediately after the stop bit is detected.
- valid and frame_err are never high in the same cycle.
- Reset mid-frame: all state is cleared immediately, with no partial-byte output. The next frame is received normally once rx idles high.
- Latency (defaults): start edge to valid = 2 sync cycles + 9.5 bit periods ≈ 49,402 cycles.

Decomposition:
- Shared package uart_pkg:
  - State encoding: IDLE, START, DATA, STOP.
  - Default BAUD/OVERSAMPLE constants.
  - DIV computation function, shared with the future transmitter.
- Sub-module uart_tick_gen: parameterised divider with a one-cycle tick output and a synchronous reload input. Enable pulse, not a derived clock.

Test Plan:
- Reset: hold nrst=0 with rx=1 toggling in_clk -> data=0, valid=0, frame_err=0, busy=0. Release -> all outputs unchanged.
- Single frame: drive 0xA5, 8N1, 5200-cycle bits -> exactly one valid pulse, data=8'hA5, frame_err never high, busy falls with valid.
- Glitch: rx low for 2000 cycles, then high -> busy pulses, then returns to 0. No valid, no frame_err.
- Frame error: drive 0x3C with stop bit low, held low 3 bit times -> one frame_err pulse, no valid, data stays 8'hA5. No start detected until rx returns high.
- Back-to-back: 0x00 then 0xFF with zero idle gap -> two valid pulses, data=8'h00 then 8'hFF.
- Reset mid-frame: assert nrst=0 during bit 3 of 0x12, then send 0x55 -> outputs clear asynchronously, no valid for 0x12, then one valid with data=8'h55.
